mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Data-memory access stage directly downstream of the instruction decode/control logic.
- Consumes the decoded memory controls (load/store type code, store enable, load enable) together with the EX-stage effective address and store data.
- Drives a request/grant/response data-memory port and returns the extended load result to writeback.
- Holds the pipeline with a stall while an access is outstanding, and flags misaligned and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT before abort (1..65535)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  1  EX stage presents a valid instruction this cycle
ld_st_ctrl  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
mem_write  in  1  store enable from control
mem_to_reg  in  1  load enable from control
addr  in  32  byte effective address
store_data  in  32  rt value, right-justified
dmem_req  out  1  memory request, held until grant
dmem_we  out  4  byte write enables; 0000 for loads
dmem_addr  out  32  {addr[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  memory accepted request this cycle
dmem_rvalid  in  1  load data valid
dmem_rdata  in  32  raw load word
stall  out  1  freeze upstream pipeline
load_data  out  32  extended load result
load_valid  out  1  one-cycle pulse, load_data fresh
misalign_err  out  1  one-cycle pulse, access rejected
bus_err  out  1  one-cycle pulse, access aborted on timeout

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - load_data=0, load_valid=0, misalign_err=0, bus_err=0, timeout counter=0.
  - Reset mid-access drops dmem_req in the same cycle; a late dmem_rvalid is ignored.
- Accept: in IDLE when req_valid & (mem_write|mem_to_reg) and the access is aligned. Controls, address, and data are registered at the clock edge.
- Store vs load: the access is a store iff ld_st_ctrl>=101; otherwise it is a load.
- Alignment:
  - Byte accesses are always aligned.
  - Half accesses (LH/LHU/SH) require addr[0]=0.
  - Word accesses (LW/SW) require addr[1:0]=00.
  - A misaligned request is not accepted. misalign_err pulses the next cycle, with no memory access and no stall.
- stall = (state!=IDLE) | accept. It is combinational, so it is high in the accept cycle itself.
- States:
  - IDLE: on accept, go to REQ.
  - REQ: dmem_req=1 with stable addr/we/wdata. On dmem_gnt, a store goes to IDLE and a load goes to WAIT.
  - WAIT: dmem_req=0. On dmem_rvalid, register the extended result into load_data, pulse load_valid the next cycle, and go to IDLE.
- rvalid sampling: dmem_rvalid is sampled only in WAIT. It is ignored in all other states, including a same-cycle-as-gnt response.
- Byte lanes (big-endian):
  - Offset 0 selects bits[31:24] (we 1000), offset 1 selects [23:16], offset 2 selects [15:8], offset 3 selects [7:0].
  - Halfword offset 0 selects [31:16] (we 1100) and offset 2 selects [15:0] (we 0011).
  - Word accesses use we 1111.
  - For SB, dmem_wdata = {4{store_data[7:0]}}. For SH, dmem_wdata = {2{store_data[15:0]}}.
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. load_data holds its value until the next completed load.
- Timing:
  - Zero-wait store (gnt in first REQ cycle): stall high 2 cycles (accept + REQ).
  - Minimum load: stall high 3 cycles (accept, REQ, WAIT); load_valid in the 4th cycle, when stall=0.
- Timeout:
  - The counter clears on accept and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES, the access is abandoned: state goes to IDLE, dmem_req drops, bus_err pulses 1 cycle, and load_valid is not asserted.
- New requests: a new req_valid presented while not IDLE is ignored (upstream is stalled). A request in the cycle load_valid pulses is accepted normally.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, gnt in 1st REQ cycle -> dmem_addr=0x100, we=1111, wdata=0xDEADBEEF; stall high exactly 2 cycles.
- SB addr=0x103, data=0x000000A5 -> we=0001, wdata=0xA5A5A5A5; SH addr=0x102, data=0x1234 -> we=0011, wdata=0x12341234.
- LB addr=0x201, rdata=0x1280FF00, rvalid 2 cycles after gnt -> load_data=0xFFFFFF80 with load_valid one cycle. LBU same -> 0x00000080. LH addr=0x200 -> 0x00001280. LHU addr=0x202 -> 0x0000FF00.
- LW addr=0x302, and SH addr=0x101 -> misalign_err pulses, dmem_req never asserts, stall stays 0.
- TIMEOUT_CYCLES=4 with gnt withheld -> bus_err pulses after 4 REQ cycles, back in IDLE, no load_valid. Repeat with gnt given but rvalid withheld -> same result.
- Load in WAIT, rst asserted asynchronously -> dmem_req/stall/load_valid 0 immediately. A subsequent rvalid is ignored, and the next LW completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - data-memory access stage: req/gnt/rvalid port, big-endian lanes, load extension
// Holds the pipeline while an access is outstanding; rejects misaligned accesses and aborts on timeout.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [2:0]  ld_st_ctrl,
   input  logic        mem_write,
   input  logic        mem_to_reg,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        dmem_req,
   output logic [3:0]  dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        misalign_err,
   output logic        bus_err
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t      state_q, state_d;
   logic [2:0]  ctrl_q;
   logic [1:0]  off_q;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] addr_q, wdata_q, load_data_q, load_data_d;
   logic [3:0]  we_q;
   logic        load_valid_q, load_valid_d, misalign_q, bus_err_q, bus_err_d;

   logic        aligned, mem_op, accept, timed_out;
   logic [3:0]  we_nxt;
   logic [31:0] wdata_nxt, ext_data;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;
   logic [16:0] cnt_inc;

   always_comb begin
      aligned   = 1'b1;
      we_nxt    = 4'b0000;
      wdata_nxt = store_data;
      case (ld_st_ctrl)
         3'b101: begin
            we_nxt    = 4'b1000 >> addr[1:0];
            wdata_nxt = {4{store_data[7:0]}};
         end
         3'b001, 3'b100: aligned = ~addr[0];
         3'b110: begin
            aligned   = ~addr[0];
            we_nxt    = addr[1] ? 4'b0011 : 4'b1100;
            wdata_nxt = {2{store_data[15:0]}};
         end
         3'b010: aligned = (addr[1:0] == 2'b00);
         3'b111: begin
            aligned = (addr[1:0] == 2'b00);
            we_nxt  = 4'b1111;
         end
         default: aligned = 1'b1;
      endcase
   end

   assign mem_op    = req_valid & (mem_write | mem_to_reg);
   assign accept    = ~rst & (state_q == S_IDLE) & mem_op & aligned;
   assign cnt_inc   = {1'b0, cnt_q} + 17'd1;
   assign timed_out = (cnt_inc >= 17'(TIMEOUT_CYCLES));

   // Lane 0 is the most significant byte (big-endian).
   always_comb begin
      case (off_q)
         2'd0:    rbyte = dmem_rdata[31:24];
         2'd1:    rbyte = dmem_rdata[23:16];
         2'd2:    rbyte = dmem_rdata[15:8];
         default: rbyte = dmem_rdata[7:0];
      endcase
      rhalf = off_q[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
      case (ctrl_q)
         3'b000:  ext_data = {{24{rbyte[7]}}, rbyte};
         3'b001:  ext_data = {{16{rhalf[15]}}, rhalf};
         3'b011:  ext_data = {24'd0, rbyte};
         3'b100:  ext_data = {16'd0, rhalf};
         default: ext_data = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      bus_err_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_REQ;
               cnt_d   = 16'd0;
            end
         end
         S_REQ: begin
            cnt_d = cnt_inc[15:0];
            if (dmem_gnt) begin
               state_d = (ctrl_q >= 3'b101) ? S_IDLE : S_WAIT;
            end else if (timed_out) begin
               state_d   = S_IDLE;
               bus_err_d = 1'b1;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_inc[15:0];
            if (dmem_rvalid) begin
               state_d      = S_IDLE;
               load_data_d  = ext_data;
               load_valid_d = 1'b1;
            end else if (timed_out) begin
               state_d   = S_IDLE;
               bus_err_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ctrl_q       <= 3'd0;
         off_q        <= 2'd0;
         cnt_q        <= 16'd0;
         addr_q       <= 32'd0;
         we_q         <= 4'd0;
         wdata_q      <= 32'd0;
         load_data_q  <= 32'd0;
         load_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         bus_err_q    <= bus_err_d;
         misalign_q   <= (state_q == S_IDLE) & mem_op & ~aligned;
         if (accept) begin
            ctrl_q  <= ld_st_ctrl;
            off_q   <= addr[1:0];
            addr_q  <= {addr[31:2], 2'b00};
            we_q    <= we_nxt;
            wdata_q <= wdata_nxt;
         end
      end
   end

   assign dmem_req     = (state_q == S_REQ);
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_wdata   = wdata_q;
   assign stall        = (state_q != S_IDLE) | accept;
   assign load_data    = load_data_q;
   assign load_valid   = load_valid_q;
   assign misalign_err = misalign_q;
   assign bus_err      = bus_err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
// Expected port values come from byte-lane arithmetic and a closed-form timeout rule.
module tb_mem_access_unit;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, mem_write, mem_to_reg;
   logic [2:0]  ld_st_ctrl;
   logic [31:0] addr, store_data;
   logic        dmem_req, dmem_gnt, dmem_rvalid;
   logic [3:0]  dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        stall, load_valid, misalign_err, bus_err;
   logic [31:0] load_data;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .ld_st_ctrl(ld_st_ctrl),
      .mem_write(mem_write), .mem_to_reg(mem_to_reg), .addr(addr), .store_data(store_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .stall(stall), .load_data(load_data), .load_valid(load_valid),
      .misalign_err(misalign_err), .bus_err(bus_err)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_load;
   logic [31:0] obs_addr, obs_wdata;
   logic [3:0]  obs_we;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int acc_size(input logic [2:0] c);
      case (c)
         3'd0, 3'd3, 3'd5: return 1;
         3'd1, 3'd4, 3'd6: return 2;
         default:          return 4;
      endcase
   endfunction

   function automatic logic [3:0] model_we(input logic [2:0] c, input logic [31:0] a);
      int sz = acc_size(c);
      int off = int'(a[1:0]);
      logic [3:0] we = 4'd0;
      if (c < 3'd5) return 4'd0;
      for (int i = 0; i < 4; i++)
         if (i >= off && i < off + sz) we[3-i] = 1'b1;
      return we;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] c, input logic [31:0] d);
      int sz = acc_size(c);
      logic [31:0] w = 32'd0;
      for (int i = 0; i < 4; i++)
         w = (w << 8) | ((d >> (8 * ((sz - 1) - (i % sz)))) & 32'hFF);
      return w;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] c, input logic [31:0] a, input logic [31:0] r);
      int sz = acc_size(c);
      int off = int'(a[1:0]);
      logic [31:0] v = 32'd0;
      for (int i = 0; i < sz; i++)
         v = (v << 8) | ((r >> (8 * (3 - (off + i)))) & 32'hFF);
      if ((c == 3'd0 || c == 3'd1) && v[8*sz-1]) v = v | (32'hFFFFFFFF << (8 * sz));
      return v;
   endfunction

   // gd: REQ cycles before gnt; rd: WAIT cycles before rvalid.
   task automatic do_access(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                            input int gd, input int rd, input logic [31:0] rdat, input string tag);
      bit is_st, mis, abort;
      int n_busy;
      is_st = (c >= 3'd5);
      mis   = (int'(a[1:0]) % acc_size(c)) != 0;
      abort = (gd >= TO) || (!is_st && rd > 0 && gd + 1 + rd >= TO);
      if (abort) n_busy = (gd >= TO) ? TO : ((gd + 2 > TO) ? gd + 2 : TO);
      else       n_busy = is_st ? gd + 1 : gd + 2 + rd;

      @(negedge clk);
      req_valid = 1'b1; ld_st_ctrl = c; mem_write = is_st; mem_to_reg = !is_st;
      addr = a; store_data = d; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      #1 check({tag, "_stall_accept"}, stall, !mis);
      @(negedge clk);
      req_valid = 1'b0; addr = $urandom; store_data = $urandom; ld_st_ctrl = 3'($urandom);
      check({tag, "_misalign"}, misalign_err, mis);
      if (mis) begin
         check({tag, "_mis_req"}, dmem_req, 0);
         check({tag, "_mis_stall"}, stall, 0);
         return;
      end
      obs_addr = dmem_addr; obs_we = dmem_we; obs_wdata = dmem_wdata;
      check({tag, "_addr"}, dmem_addr, a & 32'hFFFFFFFC);
      check({tag, "_we"}, dmem_we, model_we(c, a));
      if (is_st) check({tag, "_wdata"}, dmem_wdata, model_wdata(c, d));
      for (int k = 1; k <= n_busy; k++) begin
         check({tag, "_req"}, dmem_req, k <= gd + 1);
         check({tag, "_stall_busy"}, stall, 1);
         check({tag, "_lv_busy"}, load_valid, 0);
         dmem_gnt    = (k == gd + 1);
         dmem_rvalid = (k <= gd + 1) ? 1'($urandom_range(0, 1)) : (k == gd + 2 + rd);
         dmem_rdata  = (k == gd + 2 + rd) ? rdat : $urandom;
         @(negedge clk);
      end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      if (!is_st && !abort) exp_load = model_load(c, a, rdat);
      check({tag, "_stall_done"}, stall, 0);
      check({tag, "_req_done"}, dmem_req, 0);
      check({tag, "_load_valid"}, load_valid, !is_st && !abort);
      check({tag, "_bus_err"}, bus_err, abort);
      check({tag, "_load_data"}, load_data, exp_load);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; ld_st_ctrl = 3'd0; mem_write = 1'b0; mem_to_reg = 1'b0;
      addr = 32'd0; store_data = 32'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
      exp_load = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_req", dmem_req, 0);
      check("rst_we", dmem_we, 0);
      check("rst_addr", dmem_addr, 0);
      check("rst_wdata", dmem_wdata, 0);
      check("rst_stall", stall, 0);
      check("rst_load_data", load_data, 0);
      check("rst_flags", {load_valid, misalign_err, bus_err}, 0);
      rst = 1'b0;

      do_access(3'd7, 32'h100, 32'hDEADBEEF, 0, 0, 0, "sw");
      check("sw_addr_c", obs_addr, 32'h100);
      check("sw_we_c", obs_we, 4'b1111);
      check("sw_wdata_c", obs_wdata, 32'hDEADBEEF);
      do_access(3'd5, 32'h103, 32'h000000A5, 0, 0, 0, "sb");
      check("sb_we_c", obs_we, 4'b0001);
      check("sb_wdata_c", obs_wdata, 32'hA5A5A5A5);
      do_access(3'd6, 32'h102, 32'h00001234, 1, 0, 0, "sh");
      check("sh_we_c", obs_we, 4'b0011);
      check("sh_wdata_c", obs_wdata, 32'h12341234);
      do_access(3'd0, 32'h201, 32'd0, 0, 1, 32'h1280FF00, "lb");
      check("lb_c", load_data, 32'hFFFFFF80);
      do_access(3'd3, 32'h201, 32'd0, 0, 1, 32'h1280FF00, "lbu");
      check("lbu_c", load_data, 32'h00000080);
      do_access(3'd1, 32'h200, 32'd0, 0, 1, 32'h1280FF00, "lh");
      check("lh_c", load_data, 32'h00001280);
      do_access(3'd4, 32'h202, 32'd0, 0, 1, 32'h1280FF00, "lhu");
      check("lhu_c", load_data, 32'h0000FF00);
      do_access(3'd2, 32'h302, 32'd0, 0, 0, 0, "lw_mis");
      do_access(3'd6, 32'h101, 32'h1234, 0, 0, 0, "sh_mis");
      do_access(3'd7, 32'h500, 32'h11111111, 10, 0, 0, "to_gnt");
      do_access(3'd2, 32'h504, 32'd0, 0, 10, 32'h22222222, "to_rvalid");
      do_access(3'd2, 32'h508, 32'd0, 3, 0, 32'h33333333, "gnt_last");

      @(negedge clk);
      req_valid = 1'b1; ld_st_ctrl = 3'd2; mem_to_reg = 1'b1; mem_write = 1'b0; addr = 32'h400;
      @(negedge clk);
      req_valid = 1'b0; dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      check("rstw_stall_pre", stall, 1);
      #2 rst = 1'b1;
      #1;
      check("rstw_req", dmem_req, 0);
      check("rstw_stall", stall, 0);
      check("rstw_lv", load_valid, 0);
      @(negedge clk);
      rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      check("rstw_late_lv", load_valid, 0);
      check("rstw_late_data", load_data, 0);
      check("rstw_late_stall", stall, 0);
      exp_load = 32'd0;
      do_access(3'd2, 32'h404, 32'd0, 0, 0, 32'h0BADBEEF, "lw_after_rst");

      for (int i = 0; i < 200; i++)
         do_access(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 4),
                   $urandom_range(0, 3), $urandom, "rnd");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
